// File: rtl/fu_issue_stage_if.sv
// Handshake and operand bus between upstream, the issue stage and the FU.
interface fu_issue_stage_if #(
  parameter int TAG_W = 4
);
  // upstream -> stage
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [31:0]      in_c;
  logic [4:0]       in_inst;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  // stage -> FU / result tracking
  logic [31:0]      fu_a;
  logic [31:0]      fu_b;
  logic [31:0]      fu_c;
  logic [4:0]       fu_inst;
  logic             res_valid;
  logic [TAG_W-1:0] res_tag;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_c, in_inst, in_tag, flush,
    input  in_ready, fu_a, fu_b, fu_c, fu_inst, res_valid, res_tag, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_inst, in_tag, flush,
    output in_ready, fu_a, fu_b, fu_c, fu_inst, res_valid, res_tag, busy
  );
endinterface

// File: rtl/fu_issue_stage.sv
// Operand issue stage: small FIFO feeding registered FU operand lines, with
// MADD operands held for the multiplier latency and a result-valid/tag strobe.
module fu_issue_stage #(
  parameter int DEPTH    = 4,
  parameter int MADD_LAT = 2,
  parameter int TAG_W    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  fu_issue_stage_if.slave      io_bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int HW = (MADD_LAT > 0) ? $clog2(MADD_LAT + 1) : 1;

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [31:0]      c;
    logic [4:0]       inst;
    logic [TAG_W-1:0] tag;
  } op_t;

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_MADD_HOLD} state_t;

  op_t              r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  state_t           r_state;
  logic [HW-1:0]    r_hold;      // edges left before the MADD result cycle
  logic [TAG_W-1:0] r_cur_tag;   // tag of the MADD being held
  logic [31:0]      r_fu_a;
  logic [31:0]      r_fu_b;
  logic [31:0]      r_fu_c;
  logic [4:0]       r_fu_inst;
  logic             r_res_valid;
  logic [TAG_W-1:0] r_res_tag;

  logic w_full, w_empty, w_push, w_pop, w_slot_free, w_head_madd;
  op_t  w_in, w_head;

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = io_bus.in_valid & ~w_full;
  // The FU slot frees up every edge except while a MADD is still counting down.
  assign w_slot_free = (r_state != S_MADD_HOLD) || (r_hold == '0);
  assign w_pop       = ~w_empty & w_slot_free;
  assign w_in        = '{a: io_bus.in_a, b: io_bus.in_b, c: io_bus.in_c,
                         inst: io_bus.in_inst, tag: io_bus.in_tag};
  assign w_head      = r_mem[r_rptr];
  assign w_head_madd = (w_head.inst[4:3] == 2'b11);

  // FIFO storage; contents need no reset since the pointers gate them
  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst && !io_bus.flush) r_mem[r_wptr] <= w_in;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge i_clk) begin
    if (i_rst || io_bus.flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Issue FSM driving the registered FU operands and result strobe
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_cur_tag   <= '0;
      r_fu_a      <= '0;
      r_fu_b      <= '0;
      r_fu_c      <= '0;
      r_fu_inst   <= '0;
      r_res_valid <= 1'b0;
      r_res_tag   <= '0;
    end else if (io_bus.flush) begin
      r_state     <= S_IDLE;
      r_hold      <= '0;
      r_fu_inst   <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      if (r_state == S_MADD_HOLD && r_hold != '0) begin
        // operands stay put; strobe the result on the last held cycle
        r_hold <= r_hold - HW'(1);
        if (r_hold == HW'(1)) begin
          r_res_valid <= 1'b1;
          r_res_tag   <= r_cur_tag;
        end
      end else if (w_pop) begin
        r_fu_a    <= w_head.a;
        r_fu_b    <= w_head.b;
        r_fu_c    <= w_head.c;
        r_cur_tag <= w_head.tag;
        if (w_head_madd) begin
          // bit 2 keeps the multiplier's gated clock running while held
          r_fu_inst <= w_head.inst | 5'b00100;
          r_hold    <= HW'(MADD_LAT);
          r_state   <= S_MADD_HOLD;
        end else begin
          r_fu_inst   <= w_head.inst;
          r_res_valid <= 1'b1;
          r_res_tag   <= w_head.tag;
          r_state     <= S_PRESENT;
        end
      end else begin
        r_fu_inst <= '0;
        r_state   <= S_IDLE;
      end
    end
  end

  assign io_bus.in_ready  = ~w_full;
  assign io_bus.busy      = ~w_empty | (r_state != S_IDLE);
  assign io_bus.fu_a      = r_fu_a;
  assign io_bus.fu_b      = r_fu_b;
  assign io_bus.fu_c      = r_fu_c;
  assign io_bus.fu_inst   = r_fu_inst;
  assign io_bus.res_valid = r_res_valid;
  assign io_bus.res_tag   = r_res_tag;
endmodule
